// File: rtl/instr_register_pkg.sv
// Shared instruction types for the instr_register queue and its scheduler.
package instr_register_pkg;

  typedef enum logic [3:0] {
    ZERO, PASSA, PASSB, ADD, SUB, MULT, DIV, MOD
  } opcode_t;

  typedef logic signed [31:0] operand_t;
  typedef logic [4:0]         address_t;

  typedef struct packed {
    opcode_t  opc;
    operand_t op_a;
    operand_t op_b;
  } instruction_t;

endpackage

// File: rtl/instr_reg_scheduler.sv
// Round-robin write-port arbiter for instr_register, plus the pointer and occupancy
// logic that turns the register file into a circular queue drained by the issue stage.
module instr_reg_scheduler
  import instr_register_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  parameter  int DEPTH   = 32,
  parameter  int ADDR_W  = 5,
  localparam int SRC_W   = $clog2(NUM_REQ)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  opcode_t  [NUM_REQ-1:0]      req_opcode,
  input  operand_t [NUM_REQ-1:0]      req_operand_a,
  input  operand_t [NUM_REQ-1:0]      req_operand_b,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic                        load_en,
  output opcode_t                     opcode,
  output operand_t                    operand_a,
  output operand_t                    operand_b,
  output logic [ADDR_W-1:0]           write_pointer,
  output logic [ADDR_W-1:0]           read_pointer,
  input  instruction_t                instruction_word,
  output logic                        iss_valid,
  input  logic                        iss_ready,
  output instruction_t                iss_word,
  output logic [SRC_W-1:0]            iss_src,
  output logic [ADDR_W:0]             count,
  output logic                        full,
  output logic                        empty
);

  localparam int CNT_W = ADDR_W + 1;

  logic [SRC_W-1:0]  r_rr_ptr;
  logic [SRC_W-1:0]  r_wsrc;
  logic              r_load_en;
  opcode_t           r_opc;
  operand_t          r_opa;
  operand_t          r_opb;
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [SRC_W-1:0]  r_src_tbl [DEPTH];

  logic [CNT_W:0]    w_occ;
  logic              w_grant_ok;
  logic              w_grant_any;
  logic [NUM_REQ-1:0] w_grant;
  logic [SRC_W-1:0]  w_grant_idx;
  logic [SRC_W-1:0]  w_rr_next;
  logic              w_deq;

  // The pending write counts as occupied so a grant can never overrun the queue.
  assign w_occ      = {1'b0, r_count} + {{CNT_W{1'b0}}, r_load_en};
  assign w_grant_ok = !reset && (w_occ < (CNT_W+1)'(DEPTH));
  assign w_deq      = iss_valid && iss_ready;

  always_comb begin
    logic [SRC_W:0]   sum;
    logic [SRC_W-1:0] idx;
    w_grant     = '0;
    w_grant_idx = '0;
    w_grant_any = 1'b0;
    sum         = '0;
    idx         = '0;
    if (w_grant_ok) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        sum = {1'b0, r_rr_ptr} + (SRC_W+1)'(k);
        if (sum >= (SRC_W+1)'(NUM_REQ)) begin
          sum = sum - (SRC_W+1)'(NUM_REQ);
        end
        idx = sum[SRC_W-1:0];
        if (!w_grant_any && req_valid[idx]) begin
          w_grant[idx] = 1'b1;
          w_grant_idx  = idx;
          w_grant_any  = 1'b1;
        end
      end
    end
  end

  assign w_rr_next = (w_grant_idx == SRC_W'(NUM_REQ - 1)) ? '0 : w_grant_idx + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rr_ptr  <= '0;
      r_wsrc    <= '0;
      r_load_en <= 1'b0;
      r_opc     <= ZERO;
      r_opa     <= '0;
      r_opb     <= '0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
    end else begin
      r_load_en <= w_grant_any;
      if (w_grant_any) begin
        r_opc    <= req_opcode[w_grant_idx];
        r_opa    <= req_operand_a[w_grant_idx];
        r_opb    <= req_operand_b[w_grant_idx];
        r_wsrc   <= w_grant_idx;
        r_rr_ptr <= w_rr_next;
      end
      if (r_load_en) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_deq) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_count <= r_count + CNT_W'(r_load_en) - CNT_W'(w_deq);
    end
  end

  // Source ids live beside the queue entries; no reset needed, iss_src is gated by iss_valid.
  always_ff @(posedge clk) begin
    if (!reset && r_load_en) begin
      r_src_tbl[r_wr_ptr] <= r_wsrc;
    end
  end

  assign req_ready     = w_grant;
  assign load_en       = r_load_en;
  assign opcode        = r_opc;
  assign operand_a     = r_opa;
  assign operand_b     = r_opb;
  assign write_pointer = r_wr_ptr;
  assign read_pointer  = r_rd_ptr;
  assign iss_valid     = (r_count != '0);
  assign iss_word      = instruction_word;
  assign iss_src       = iss_valid ? r_src_tbl[r_rd_ptr] : '0;
  assign count         = r_count;
  assign full          = (w_occ == (CNT_W+1)'(DEPTH));
  assign empty         = (r_count == '0);

endmodule

// File: tb/tb_instr_reg_scheduler.sv
// Directed bench for instr_reg_scheduler with a behavioural instr_register alongside.
module tb_instr_reg_scheduler;
  import instr_register_pkg::*;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic [3:0]           req_valid = '0;
  opcode_t  [3:0]       req_opcode;
  operand_t [3:0]       req_operand_a;
  operand_t [3:0]       req_operand_b;
  logic [3:0]           req_ready;
  logic                 load_en;
  opcode_t              opcode;
  operand_t             operand_a, operand_b;
  logic [4:0]           write_pointer, read_pointer;
  instruction_t         instruction_word;
  logic                 iss_valid;
  logic                 iss_ready = 1'b0;
  instruction_t         iss_word;
  logic [1:0]           iss_src;
  logic [5:0]           count;
  logic                 full, empty;

  instr_reg_scheduler dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_opcode(req_opcode),
    .req_operand_a(req_operand_a), .req_operand_b(req_operand_b),
    .req_ready(req_ready), .load_en(load_en), .opcode(opcode),
    .operand_a(operand_a), .operand_b(operand_b),
    .write_pointer(write_pointer), .read_pointer(read_pointer),
    .instruction_word(instruction_word),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_word(iss_word),
    .iss_src(iss_src), .count(count), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  instruction_t mem [32];
  always @(posedge clk) if (load_en) mem[write_pointer] <= '{opc: opcode, op_a: operand_a, op_b: operand_b};
  assign instruction_word = mem[read_pointer];

  int n_checks = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Leaves the caller at posedge+1 of the first cycle with reset released.
  task automatic do_reset();
    cyc();
    reset = 1'b1; req_valid = 4'hF; iss_ready = 1'b0;
    #1 chk("grant_in_reset", req_ready, 4'b0000);
    cyc();
    reset = 1'b0; req_valid = 4'h0;
  endtask

  function automatic instruction_t mk(input opcode_t o, input operand_t a, input operand_t b);
    mk = '{opc: o, op_a: a, op_b: b};
  endfunction

  typedef struct {
    logic [3:0] rv;
    logic       ir;
    logic [3:0] rdy;
    logic       le;
    logic [5:0] cnt;
    logic [4:0] wp;
    logic       iv;
  } vec_t;

  vec_t tbl [10];
  instruction_t sb [$];
  int srcq [$];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int grants, pops, exp_rr, tag;
    bit saw_w, saw_r;
    logic [4:0] prev_wp, prev_rp;

    tbl[0] = '{4'hF, 1'b0, 4'b0001, 1'b0, 6'd0, 5'd0, 1'b0};
    tbl[1] = '{4'hF, 1'b0, 4'b0010, 1'b1, 6'd0, 5'd0, 1'b0};
    tbl[2] = '{4'hF, 1'b0, 4'b0100, 1'b1, 6'd1, 5'd1, 1'b1};
    tbl[3] = '{4'hF, 1'b0, 4'b1000, 1'b1, 6'd2, 5'd2, 1'b1};
    tbl[4] = '{4'hF, 1'b0, 4'b0001, 1'b1, 6'd3, 5'd3, 1'b1};
    tbl[5] = '{4'hF, 1'b0, 4'b0010, 1'b1, 6'd4, 5'd4, 1'b1};
    tbl[6] = '{4'hF, 1'b0, 4'b0100, 1'b1, 6'd5, 5'd5, 1'b1};
    tbl[7] = '{4'hF, 1'b0, 4'b1000, 1'b1, 6'd6, 5'd6, 1'b1};
    tbl[8] = '{4'h0, 1'b0, 4'b0000, 1'b1, 6'd7, 5'd7, 1'b1};
    tbl[9] = '{4'h0, 1'b0, 4'b0000, 1'b0, 6'd8, 5'd8, 1'b1};

    for (int i = 0; i < 4; i++) begin
      req_opcode[i] = ZERO; req_operand_a[i] = '0; req_operand_b[i] = '0;
    end

    // Reset state and single-instruction latency
    do_reset();
    #1;
    chk("rst_load_en", load_en, 0);
    chk("rst_opcode", opcode, ZERO);
    chk("rst_operand_a", operand_a, 0);
    chk("rst_operand_b", operand_b, 0);
    chk("rst_wp", write_pointer, 0);
    chk("rst_rp", read_pointer, 0);
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_iss_valid", iss_valid, 0);
    chk("rst_iss_src", iss_src, 0);
    chk("rst_ready", req_ready, 0);
    req_valid = 4'b0001; req_opcode[0] = ADD; req_operand_a[0] = 5; req_operand_b[0] = 3;
    #1 chk("t1_ready", req_ready, 4'b0001);
    cyc();
    req_valid = 4'b0000;
    #1;
    chk("t1_load_en", load_en, 1);
    chk("t1_wp", write_pointer, 0);
    chk("t1_opcode", opcode, ADD);
    chk("t1_opa", operand_a, 5);
    chk("t1_opb", operand_b, 3);
    chk("t1_iss_valid_early", iss_valid, 0);
    cyc();
    #1;
    chk("t1_iss_valid", iss_valid, 1);
    chk("t1_iss_word", iss_word, mk(ADD, 5, 3));
    chk("t1_iss_src", iss_src, 0);
    chk("t1_count", count, 1);
    chk("t1_load_en_low", load_en, 0);
    iss_ready = 1'b1;
    cyc();
    iss_ready = 1'b0;
    #1;
    chk("t1_count_after_deq", count, 0);
    chk("t1_rp", read_pointer, 1);
    chk("t1_empty", empty, 1);
    chk("t1_held_opa", operand_a, 5);
    chk("t1_held_wp", write_pointer, 1);

    // Round-robin with all requesters valid
    do_reset();
    for (int i = 0; i < 4; i++) begin
      req_opcode[i] = opcode_t'(i + 1);
      req_operand_a[i] = i * 16 + 1;
      req_operand_b[i] = i * 16 + 2;
    end
    for (int v = 0; v < 10; v++) begin
      req_valid = tbl[v].rv; iss_ready = tbl[v].ir;
      #1;
      chk($sformatf("rr%0d_ready", v), req_ready, tbl[v].rdy);
      chk($sformatf("rr%0d_load_en", v), load_en, tbl[v].le);
      chk($sformatf("rr%0d_count", v), count, tbl[v].cnt);
      chk($sformatf("rr%0d_wp", v), write_pointer, tbl[v].wp);
      chk($sformatf("rr%0d_iss_valid", v), iss_valid, tbl[v].iv);
      cyc();
    end
    iss_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk($sformatf("drain%0d_valid", k), iss_valid, 1);
      chk($sformatf("drain%0d_src", k), iss_src, k % 4);
      chk($sformatf("drain%0d_word", k), iss_word,
          mk(opcode_t'(k % 4 + 1), (k % 4) * 16 + 1, (k % 4) * 16 + 2));
      cyc();
    end
    iss_ready = 1'b0;
    #1 chk("drain_empty", empty, 1);

    // Fill to full, then one dequeue reopens the write port a cycle later
    do_reset();
    req_valid = 4'b0001;
    grants = 0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (req_ready[0]) grants++;
      if (full && count == 6'd32) break;
      cyc();
    end
    chk("full_grants", grants, 32);
    chk("full_flag", full, 1);
    chk("full_count", count, 32);
    chk("full_ready", req_ready, 0);
    chk("full_wp_wrap", write_pointer, 0);
    iss_ready = 1'b1;
    #1 chk("full_deq_same_cycle_ready", req_ready, 0);
    cyc();
    iss_ready = 1'b0;
    #1;
    chk("full_after_deq_count", count, 31);
    chk("full_after_deq_full", full, 0);
    chk("full_after_deq_ready", req_ready, 4'b0001);
    chk("full_after_deq_rp", read_pointer, 1);
    cyc();
    req_valid = 4'b0000;

    // Steady-state streaming: 40 transfers with FIFO order and pointer wrap
    do_reset();
    iss_ready = 1'b1;
    grants = 0; pops = 0; exp_rr = 0; tag = 100;
    saw_w = 0; saw_r = 0; prev_wp = 0; prev_rp = 0;
    sb.delete(); srcq.delete();
    for (int c = 0; c < 200 && pops < 40; c++) begin
      req_valid = (grants < 40) ? 4'hF : 4'h0;
      for (int i = 0; i < 4; i++) begin
        req_opcode[i] = opcode_t'(i + 1);
        req_operand_a[i] = tag;
        req_operand_b[i] = i;
      end
      #1;
      if (grants < 40) begin
        chk("ss_grant", req_ready, 4'b0001 << exp_rr);
        sb.push_back(mk(opcode_t'(exp_rr + 1), tag, exp_rr));
        srcq.push_back(exp_rr);
        grants++;
        exp_rr = (exp_rr + 1) % 4;
      end else begin
        chk("ss_nogrant", req_ready, 0);
      end
      if (iss_valid) begin
        if (sb.size() == 0) begin
          chk("ss_spurious_valid", iss_valid, 0);
        end else begin
          chk("ss_word", iss_word, sb[0]);
          chk("ss_src", iss_src, srcq[0]);
          void'(sb.pop_front());
          void'(srcq.pop_front());
          pops++;
        end
      end
      if (prev_wp == 5'd31 && write_pointer == 5'd0) saw_w = 1;
      if (prev_rp == 5'd31 && read_pointer == 5'd0) saw_r = 1;
      prev_wp = write_pointer; prev_rp = read_pointer;
      tag++;
      cyc();
    end
    iss_ready = 1'b0;
    #1;
    chk("ss_pops", pops, 40);
    chk("ss_wp_wrapped", saw_w, 1);
    chk("ss_rp_wrapped", saw_r, 1);
    chk("ss_empty_end", empty, 1);
    chk("ss_wp_end", write_pointer, 8);
    chk("ss_rp_end", read_pointer, 8);

    // Commit and dequeue in the same cycle at count 5
    do_reset();
    req_valid = 4'b0001;
    repeat (5) cyc();
    req_valid = 4'b0000;
    cyc();
    #1 chk("cd_count5", count, 5);
    req_valid = 4'b0001;
    cyc();
    req_valid = 4'b0000; iss_ready = 1'b1;
    #1;
    chk("cd_load_en", load_en, 1);
    chk("cd_count_pre", count, 5);
    cyc();
    iss_ready = 1'b0;
    #1;
    chk("cd_count_post", count, 5);
    chk("cd_rp", read_pointer, 1);
    chk("cd_wp", write_pointer, 6);

    // Reset while a write is pending
    do_reset();
    req_valid = 4'b0001;
    repeat (4) cyc();
    req_valid = 4'b0000;
    #1;
    chk("mr_load_en_pre", load_en, 1);
    chk("mr_count_pre", count, 3);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    #1;
    chk("mr_load_en", load_en, 0);
    chk("mr_count", count, 0);
    chk("mr_wp", write_pointer, 0);
    chk("mr_rp", read_pointer, 0);
    chk("mr_iss_valid", iss_valid, 0);
    chk("mr_empty", empty, 1);
    chk("mr_iss_src", iss_src, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
